// File: rtl/hog_pkg.sv
// Shared types and constants for the HOG block serializer.
package hog_pkg;

    localparam int unsigned BID_W      = 13;
    localparam int unsigned DEF_DATA_W = 288;
    localparam int unsigned DEF_BIN_W  = 32;
    localparam int unsigned NBEATS     = 4 * DEF_DATA_W / DEF_BIN_W;

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } hog_state_e;

    typedef struct packed {
        logic [BID_W-1:0]      bid;
        logic [DEF_DATA_W-1:0] fea_a;
        logic [DEF_DATA_W-1:0] fea_b;
        logic [DEF_DATA_W-1:0] fea_c;
        logic [DEF_DATA_W-1:0] fea_d;
    } hog_entry_t;

endpackage

// File: rtl/hog_blk_fifo.sv
// Two-entry block FIFO with full/empty flags; a push into a full FIFO is
// accepted when a pop happens on the same cycle.
module hog_blk_fifo
    import hog_pkg::*;
#(
    parameter type T = hog_entry_t
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  T     din,
    input  logic pop,
    output T     dout,
    output logic full,
    output logic empty
);

    T           mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       push_ok;
    logic       pop_ok;

    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= ~wr_ptr;
            if (pop_ok)  rd_ptr <= ~rd_ptr;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);

endmodule

// File: rtl/hog_block_serializer.sv
// Serializes queued HOG blocks (4 cells x DATA_W) into BIN_W beats.
// Optional macro HOG_SER_DROP_CNT_EN adds the saturating o_drop_cnt port.
module hog_block_serializer
    import hog_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned BIN_W  = DEF_BIN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic [BID_W-1:0]  i_bid,
    input  logic [DATA_W-1:0] i_fea_a,
    input  logic [DATA_W-1:0] i_fea_b,
    input  logic [DATA_W-1:0] i_fea_c,
    input  logic [DATA_W-1:0] i_fea_d,
    output logic              o_valid,
    input  logic              o_ready,
    output logic [BIN_W-1:0]  o_data,
    output logic [BID_W-1:0]  o_bid,
    output logic              o_sof,
    output logic              o_eof,
    output logic              o_ovf
`ifdef HOG_SER_DROP_CNT_EN
    ,
    output logic [15:0]       o_drop_cnt
`endif
);

    localparam int unsigned NB     = 4 * DATA_W / BIN_W;
    localparam int unsigned BEAT_W = $clog2(NB + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NB - 1);

    if (DATA_W % BIN_W != 0) begin : g_bad_width
        $error("DATA_W must be a multiple of BIN_W");
    end

    // Entry sized from this instance's parameters rather than the package defaults.
    typedef struct packed {
        logic [BID_W-1:0]  bid;
        logic [DATA_W-1:0] fea_a;
        logic [DATA_W-1:0] fea_b;
        logic [DATA_W-1:0] fea_c;
        logic [DATA_W-1:0] fea_d;
    } entry_t;

    hog_state_e        state;
    hog_state_e        state_nxt;
    logic [BEAT_W-1:0] beat_cnt;
    entry_t            fifo_din;
    entry_t            head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              hs;
    logic              last_hs;
    logic              drop;
    logic [4*DATA_W-1:0] blk_vec;

    assign fifo_din = '{bid: i_bid, fea_a: i_fea_a, fea_b: i_fea_b,
                        fea_c: i_fea_c, fea_d: i_fea_d};

    hog_blk_fifo #(
        .T (entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (i_valid),
        .din   (fifo_din),
        .pop   (last_hs),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign hs      = (state == ST_SEND) && o_ready;
    assign last_hs = hs && (beat_cnt == LAST_BEAT);
    assign drop    = i_valid && fifo_full && !last_hs;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            beat_cnt <= '0;
            o_ovf    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (hs) beat_cnt <= last_hs ? '0 : beat_cnt + BEAT_W'(1);
            if (drop) o_ovf <= 1'b1;
        end
    end

    // After a last-beat pop another block remains if the FIFO was full or one is arriving now.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (!fifo_empty) state_nxt = ST_SEND;
            ST_SEND: if (last_hs && !(fifo_full || i_valid)) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign blk_vec = {head.fea_d, head.fea_c, head.fea_b, head.fea_a};

    always_comb begin
        o_valid = 1'b0;
        o_data  = '0;
        o_bid   = '0;
        o_sof   = 1'b0;
        o_eof   = 1'b0;
        if (state == ST_SEND) begin
            o_valid = 1'b1;
            o_data  = blk_vec[int'(beat_cnt) * BIN_W +: BIN_W];
            o_bid   = head.bid;
            o_sof   = (beat_cnt == '0);
            o_eof   = (beat_cnt == LAST_BEAT);
        end
    end

`ifdef HOG_SER_DROP_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_drop_cnt <= '0;
        end else if (drop && (o_drop_cnt != '1)) begin
            o_drop_cnt <= o_drop_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hog_block_serializer.sv
// Directed self-checking bench for hog_block_serializer (default parameters).
module tb_hog_block_serializer;

    localparam int NB = 36;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_valid;
    logic [12:0]  i_bid;
    logic [287:0] i_fea_a, i_fea_b, i_fea_c, i_fea_d;
    logic         o_valid;
    logic         o_ready;
    logic [31:0]  o_data;
    logic [12:0]  o_bid;
    logic         o_sof, o_eof, o_ovf;
`ifdef HOG_SER_DROP_CNT_EN
    logic [15:0]  o_drop_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int first;

    hog_block_serializer dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .i_bid   (i_bid),
        .i_fea_a (i_fea_a),
        .i_fea_b (i_fea_b),
        .i_fea_c (i_fea_c),
        .i_fea_d (i_fea_d),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_bid   (o_bid),
        .o_sof   (o_sof),
        .o_eof   (o_eof),
        .o_ovf   (o_ovf)
`ifdef HOG_SER_DROP_CNT_EN
        ,
        .o_drop_cnt (o_drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Cell c of block b: word k = {b[7:0], c, k}.
    function automatic logic [287:0] mk_cell(input logic [12:0] b, input int c);
        logic [287:0] v;
        v = '0;
        for (int k = 0; k < 9; k++) v[k*32 +: 32] = {b[7:0], 8'(c), 16'(k)};
        return v;
    endfunction

    function automatic logic [31:0] exp_word(input logic [12:0] b, input int n);
        return {b[7:0], 8'(n / 9), 16'(n % 9)};
    endfunction

    task automatic drive_in(input logic [12:0] b);
        i_valid = 1'b1;
        i_bid   = b;
        i_fea_a = mk_cell(b, 0);
        i_fea_b = mk_cell(b, 1);
        i_fea_c = mk_cell(b, 2);
        i_fea_d = mk_cell(b, 3);
    endtask

    task automatic send_blk(input logic [12:0] b);
        drive_in(b);
        @(posedge clk); #1;
        i_valid = 1'b0;
    endtask

    // Called just after a rising edge; consumes beats until stop_n handshakes.
    task automatic recv_blk(input logic [12:0] b, input bit toggle, input bit inj,
                            input logic [12:0] inj_bid, input int stop_n,
                            output int first_cyc);
        int n = 0;
        int cyc = 0;
        first_cyc = -1;
        while (n < stop_n && cyc < 400) begin
            o_ready = toggle ? ~o_ready : 1'b1;
            if (inj && n == NB - 1 && o_valid && o_ready) drive_in(inj_bid);
            @(negedge clk);
            if (o_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                check($sformatf("b%0d_data%0d", b, n), o_data, exp_word(b, n));
                check($sformatf("b%0d_bid%0d", b, n), o_bid, b);
                check($sformatf("b%0d_sof%0d", b, n), o_sof, n == 0);
                check($sformatf("b%0d_eof%0d", b, n), o_eof, n == NB - 1);
                if (o_ready) n++;
            end
            @(posedge clk); #1;
            i_valid = 1'b0;
            cyc++;
        end
        check($sformatf("b%0d_beats", b), n, stop_n);
    endtask

    initial begin
        rst = 1'b0; i_valid = 1'b0; i_bid = '0; o_ready = 1'b0;
        i_fea_a = '0; i_fea_b = '0; i_fea_c = '0; i_fea_d = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", o_valid, 0);
        check("rst_data", o_data, 0);
        check("rst_bid", o_bid, 0);
        check("rst_sof_eof", {o_sof, o_eof}, 0);
        check("rst_ovf", o_ovf, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Single block, ready held high: first beat two cycles after the strobe.
        o_ready = 1'b1;
        send_blk(13'd5);
        recv_blk(13'd5, 1'b0, 1'b0, 13'd0, NB, first);
        check("t1_latency", first, 1);
        @(negedge clk);
        check("t1_idle", o_valid, 0);
        @(posedge clk); #1;

        // Ready toggling every cycle; stalled beats must keep their value.
        send_blk(13'd9);
        recv_blk(13'd9, 1'b1, 1'b0, 13'd0, NB, first);
        check("t2_latency", first, 1);
        @(negedge clk);
        check("t2_idle", o_valid, 0);
        @(posedge clk); #1;

        // Full FIFO with a new block on the last-beat handshake: no drop, no gap.
        o_ready = 1'b0;
        send_blk(13'd20);
        send_blk(13'd21);
        recv_blk(13'd20, 1'b0, 1'b1, 13'd22, NB, first);
        check("t4_first20", first, 0);
        recv_blk(13'd21, 1'b0, 1'b0, 13'd0, NB, first);
        check("t4_first21", first, 0);
        recv_blk(13'd22, 1'b0, 1'b0, 13'd0, NB, first);
        check("t4_first22", first, 0);
        @(negedge clk);
        check("t4_idle", o_valid, 0);
        check("t4_ovf", o_ovf, 0);
`ifdef HOG_SER_DROP_CNT_EN
        check("t4_dropcnt", o_drop_cnt, 0);
`endif
        @(posedge clk); #1;

        // Three strobes with ready low: third is dropped.
        o_ready = 1'b0;
        send_blk(13'd1);
        send_blk(13'd2);
        @(negedge clk);
        check("t3_ovf_pre", o_ovf, 0);
        send_blk(13'd3);
        @(negedge clk);
        check("t3_ovf", o_ovf, 1);
`ifdef HOG_SER_DROP_CNT_EN
        check("t3_dropcnt", o_drop_cnt, 1);
`endif
        @(posedge clk); #1;
        recv_blk(13'd1, 1'b0, 1'b0, 13'd0, NB, first);
        check("t3_first1", first, 0);
        recv_blk(13'd2, 1'b0, 1'b0, 13'd0, NB, first);
        check("t3_first2", first, 0);
        repeat (3) begin
            @(negedge clk);
            check("t3_no_third", o_valid, 0);
        end
        check("t3_ovf_sticky", o_ovf, 1);
        @(posedge clk); #1;

        // Reset in the middle of a block, at beat 17.
        send_blk(13'd7);
        recv_blk(13'd7, 1'b0, 1'b0, 13'd0, 17, first);
        check("t5_pre_valid", o_valid, 1);
        check("t5_pre_data", o_data, exp_word(13'd7, 17));
        rst = 1'b0;
        #1;
        check("t5_valid", o_valid, 0);
        check("t5_data", o_data, 0);
        check("t5_bid", o_bid, 0);
        check("t5_sof_eof", {o_sof, o_eof}, 0);
        check("t5_ovf", o_ovf, 0);
`ifdef HOG_SER_DROP_CNT_EN
        check("t5_dropcnt", o_drop_cnt, 0);
`endif
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("t5_discard", o_valid, 0);
        @(posedge clk); #1;
        send_blk(13'd8);
        recv_blk(13'd8, 1'b0, 1'b0, 13'd0, NB, first);
        check("t5_latency", first, 1);
        @(negedge clk);
        check("t5_idle", o_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hog_block_serializer.md
HOG_BLOCK_SERIALIZER -- requirements
Module: hog_block_serializer

Interface
REQ-001 Parameter DATA_W, default 288: width of one cell feature vector (9 bins).
REQ-002 Parameter BIN_W, default 32: width of one bin word; DATA_W SHALL be a multiple of BIN_W.
REQ-003 Port clk  input  1  the single clock; all logic SHALL be on its rising edge.
REQ-004 Port rst  input  1  reset; SHALL be asynchronous and active-low.
REQ-005 Port i_valid  input  1  one-cycle strobe marking a new block on i_bid and i_fea_a..d.
REQ-006 Port i_bid  input  13  block id of the incoming block.
REQ-007 Ports i_fea_a, i_fea_b, i_fea_c, i_fea_d  input  DATA_W each  the four cell histograms of the block.
REQ-008 Port o_valid  output  1  a beat is presented on o_data.
REQ-009 Port o_ready  input  1  the downstream SVM stage accepts the beat.
REQ-010 Port o_data  output  BIN_W  the current bin word.
REQ-011 Port o_bid  output  13  block id of the block being sent.
REQ-012 Port o_sof / o_eof  output  1 each  first beat / last beat of a block.
REQ-013 Port o_ovf  output  1  sticky flag: a block was dropped.

Function
REQ-014 NBEATS = 4*DATA_W/BIN_W (36 at defaults); each accepted block SHALL emit exactly NBEATS beats.
REQ-015 Beat order SHALL be fea_a, fea_b, fea_c, fea_d; within a cell, word k = fea[k*BIN_W +: BIN_W], k ascending from 0.
REQ-016 A block SHALL be written to a 2-entry FIFO on any cycle with i_valid=1; the input side has no backpressure.
REQ-017 A handshake occurs when o_valid=1 and o_ready=1; the beat counter SHALL advance only on a handshake.
REQ-018 FSM states IDLE and SEND: IDLE->SEND when the FIFO is non-empty; SEND->SEND on the last-beat handshake if another entry is queued; SEND->IDLE on the last-beat handshake with the FIFO otherwise empty.
REQ-019 o_valid SHALL be 1 exactly in SEND; latency from i_valid (FIFO empty, IDLE) to the first o_valid SHALL be 2 cycles.
REQ-020 While o_valid=1 and o_ready=0, o_data, o_bid, o_sof and o_eof SHALL hold stable.
REQ-021 o_sof=1 on beat 0 only; o_eof=1 on beat NBEATS-1 only; o_bid SHALL be constant for all beats of a block.
REQ-022 The FIFO entry SHALL be popped on the last-beat handshake; back-to-back blocks SHALL stream with no idle cycle.
REQ-023 i_valid while the FIFO is full and no pop occurs that cycle: the block SHALL be dropped and o_ovf set.
REQ-024 i_valid on the same cycle as a pop from a full FIFO: the block SHALL be accepted with no drop.
REQ-025 The beat counter SHALL wrap from NBEATS-1 to 0 on the last-beat handshake.

Reset
REQ-026 Asserting rst at any time, including mid-block, SHALL clear the FIFO and beat counter, set the FSM to IDLE, and drive o_valid, o_sof, o_eof and o_ovf to 0 and o_data and o_bid to 0; the partially sent block SHALL be discarded.
REQ-027 Output o_ovf SHALL be cleared only by rst.

Configuration
REQ-028 Macro HOG_SER_DROP_CNT_EN defined: adds output port o_drop_cnt (16 bits, reset 0) that increments on every drop and saturates at 0xFFFF.
REQ-029 Macro HOG_SER_DROP_CNT_EN undefined: the port and counter SHALL be absent; all other behaviour SHALL be unchanged.

Structure
REQ-030 Package hog_pkg SHALL hold BID_W=13, the DATA_W and BIN_W defaults, NBEATS, the FSM state enum and the FIFO entry struct {bid, fea_a..d}.
REQ-031 The 2-entry FIFO SHALL be the sub-module hog_blk_fifo, with full and empty flags and same-cycle push/pop support.

Verification
REQ-032 Single block with bid=5, o_ready held 1 -> o_valid rises 2 cycles after i_valid; 36 beats follow, with o_sof on beat 0, o_eof on beat 35 and o_data equal to the expected words in order.
REQ-033 o_ready toggled 1/0 each cycle -> 36 accepted beats; every beat holds stable while stalled.
REQ-034 Three i_valid strobes on consecutive cycles with o_ready=0 -> the first two are queued, the third is dropped, o_ovf=1, and o_drop_cnt=1 with the macro defined.
REQ-035 Full FIFO with i_valid coincident with the last-beat handshake -> no drop and seamless streaming of the next block (beat 0 directly after beat 35).
REQ-036 rst asserted at beat 17 -> all outputs 0 immediately; the next block after release starts at beat 0 with o_sof=1.
